// File: rtl/ks_pluck_sequencer.sv
// Note-table sequencer driving pluck/period/prbs/drum of one ks_string voice.
// Per-note drum select is compiled in with KS_SEQ_DRUM_EN; otherwise drum_o is tied low.
module ks_pluck_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PRBS_WIDTH   = 2,
  parameter int unsigned MAX_LENGTH   = 10,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DUR_WIDTH    = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned PLUCK_CYCLES = 4,
  localparam int unsigned AW          = $clog2(DEPTH),
`ifdef KS_SEQ_DRUM_EN
  localparam int unsigned ENTRY_W     = DUR_WIDTH + DATA_WIDTH + 1
`else
  localparam int unsigned ENTRY_W     = DUR_WIDTH + DATA_WIDTH
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [ENTRY_W-1:0]    wr_data_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_en_i,
  output logic                  pluck_o,
  output logic [DATA_WIDTH-1:0] period_o,
  output logic [PRBS_WIDTH-1:0] prbs_o,
  output logic                  drum_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AW-1:0]         note_idx_o
);

  localparam int unsigned CW = DUR_WIDTH + $clog2(TICK_DIV + 1);
  localparam int unsigned PW = $clog2(PLUCK_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] MaxLen    = DATA_WIDTH'(MAX_LENGTH);
  localparam logic [CW-1:0]         TickDiv   = CW'(TICK_DIV);
  localparam logic [PW-1:0]         PluckLast = PW'(PLUCK_CYCLES - 1);
  localparam logic [15:0]           LfsrSeed  = 16'hACE1;

  if (TICK_DIV <= PLUCK_CYCLES) begin : g_bad_tick_div
    $error("ks_pluck_sequencer: TICK_DIV must be greater than PLUCK_CYCLES");
  end
  if (PRBS_WIDTH > 16 || PRBS_WIDTH == 0) begin : g_bad_prbs_width
    $error("ks_pluck_sequencer: PRBS_WIDTH must be 1..16");
  end
  if (PLUCK_CYCLES == 0 || MAX_LENGTH == 0) begin : g_bad_lengths
    $error("ks_pluck_sequencer: PLUCK_CYCLES and MAX_LENGTH must be nonzero");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_e;

  state_e                  r_state, w_state_d;
  // One extra index bit marks "walked past the last entry".
  logic [AW:0]             r_idx, w_idx_d;
  logic [CW-1:0]           r_cnt, w_cnt_d;
  logic [PW-1:0]           r_pk_cnt, w_pk_cnt_d;
  logic                    r_pluck, w_pluck_d;
  logic [DATA_WIDTH-1:0]   r_period, w_period_d;
  logic                    r_drum, w_drum_d;
  logic                    r_busy, w_busy_d;
  logic                    r_done, w_done_d;
  logic [AW-1:0]           r_note_idx, w_note_idx_d;
  logic [15:0]             r_lfsr;
  logic                    w_lfsr_fb;

  logic [ENTRY_W-1:0]      r_mem [DEPTH];
  logic [ENTRY_W-1:0]      r_rd_data;
  logic [AW-1:0]           w_rd_addr;
  logic [DUR_WIDTH-1:0]    w_ent_dur;
  logic [DATA_WIDTH-1:0]   w_ent_per;
  logic                    w_ent_drum;
  logic [DATA_WIDTH-1:0]   w_per_clamped;
  logic [CW-1:0]           w_dur_cycles;
  logic                    w_seq_end;

  assign w_ent_per  = r_rd_data[DATA_WIDTH-1:0];
  assign w_ent_dur  = r_rd_data[DATA_WIDTH +: DUR_WIDTH];
`ifdef KS_SEQ_DRUM_EN
  assign w_ent_drum = r_rd_data[ENTRY_W-1];
`else
  assign w_ent_drum = 1'b0;
`endif

  assign w_per_clamped = (w_ent_per > MaxLen) ? MaxLen : w_ent_per;
  assign w_dur_cycles  = CW'(w_ent_dur) * TickDiv - CW'(1);
  assign w_seq_end     = r_idx[AW] || (w_ent_dur == '0);

  // The read is issued on the edge entering FETCH, so the entry is valid during FETCH.
  assign w_rd_addr = w_idx_d[AW-1:0];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_cnt_d      = r_cnt;
    w_pk_cnt_d   = r_pk_cnt;
    w_pluck_d    = r_pluck;
    w_period_d   = r_period;
    w_drum_d     = r_drum;
    w_note_idx_d = r_note_idx;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;

    if (stop_i) begin
      w_state_d = StIdle;
      w_pluck_d = 1'b0;
      w_busy_d  = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) begin
            w_state_d = StFetch;
            w_idx_d   = '0;
            w_busy_d  = 1'b1;
          end
        end

        StFetch: begin
          w_pluck_d = 1'b0;
          if (w_seq_end) begin
            // idx != 0 guard keeps an empty table from looping forever.
            if (loop_en_i && (r_idx != '0)) begin
              w_idx_d = '0;
            end else begin
              w_state_d = StIdle;
              w_busy_d  = 1'b0;
              w_done_d  = 1'b1;
            end
          end else begin
            w_state_d    = StPlay;
            w_cnt_d      = w_dur_cycles;
            w_pk_cnt_d   = PluckLast;
            w_pluck_d    = (w_ent_per != '0);
            w_drum_d     = w_ent_drum;
            w_note_idx_d = r_idx[AW-1:0];
            if (w_ent_per != '0) begin
              w_period_d = w_per_clamped;
            end
          end
        end

        StPlay: begin
          if (r_pk_cnt != '0) begin
            w_pk_cnt_d = r_pk_cnt - 1'b1;
          end else begin
            w_pluck_d = 1'b0;
          end
          if (r_cnt == '0) begin
            w_state_d = StFetch;
            w_idx_d   = r_idx + 1'b1;
            w_pluck_d = 1'b0;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end

        default: begin
          w_state_d = StIdle;
          w_pluck_d = 1'b0;
          w_busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_pk_cnt   <= '0;
      r_pluck    <= 1'b0;
      r_period   <= DATA_WIDTH'(1);
      r_drum     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
      r_lfsr     <= LfsrSeed;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_cnt      <= w_cnt_d;
      r_pk_cnt   <= w_pk_cnt_d;
      r_pluck    <= w_pluck_d;
      r_period   <= w_period_d;
      r_drum     <= w_drum_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_note_idx <= w_note_idx_d;
      r_lfsr     <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  assign pluck_o    = r_pluck;
  assign period_o   = r_period;
  assign prbs_o     = r_lfsr[PRBS_WIDTH-1:0];
  assign drum_o     = r_drum;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign note_idx_o = r_note_idx;

endmodule

// File: tb/tb_ks_pluck_sequencer.sv
// Bench for ks_pluck_sequencer: a note-schedule model predicts every output cycle by cycle.
module tb_ks_pluck_sequencer;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned PRBS_WIDTH   = 2;
  localparam int unsigned MAX_LENGTH   = 10;
  localparam int unsigned DEPTH        = 16;
  localparam int unsigned DUR_WIDTH    = 4;
  localparam int unsigned TICK_DIV     = 8;
  localparam int unsigned PLUCK_CYCLES = 4;
  localparam int unsigned AW           = 4;
`ifdef KS_SEQ_DRUM_EN
  localparam int unsigned ENTRY_W      = DUR_WIDTH + DATA_WIDTH + 1;
  localparam bit          DrumEn       = 1'b1;
`else
  localparam int unsigned ENTRY_W      = DUR_WIDTH + DATA_WIDTH;
  localparam bit          DrumEn       = 1'b0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr_en_i = 1'b0;
  logic [AW-1:0]         wr_addr_i = '0;
  logic [ENTRY_W-1:0]    wr_data_i = '0;
  logic                  start_i = 1'b0;
  logic                  stop_i = 1'b0;
  logic                  loop_en_i = 1'b0;
  logic                  pluck_o;
  logic [DATA_WIDTH-1:0] period_o;
  logic [PRBS_WIDTH-1:0] prbs_o;
  logic                  drum_o;
  logic                  busy_o;
  logic                  done_o;
  logic [AW-1:0]         note_idx_o;

  ks_pluck_sequencer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PRBS_WIDTH  (PRBS_WIDTH),
    .MAX_LENGTH  (MAX_LENGTH),
    .DEPTH       (DEPTH),
    .DUR_WIDTH   (DUR_WIDTH),
    .TICK_DIV    (TICK_DIV),
    .PLUCK_CYCLES(PLUCK_CYCLES)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .loop_en_i (loop_en_i),
    .pluck_o   (pluck_o),
    .period_o  (period_o),
    .prbs_o    (prbs_o),
    .drum_o    (drum_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .note_idx_o(note_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int dur; int per; bit drum;} ent_t;
  typedef struct {bit pluck; int period; bit drum; int note; bit busy; bit done;} exp_t;

  ent_t        tbl [DEPTH];
  exp_t        q[$];
  int          m_period = 1;
  bit          m_drum = 1'b0;
  int          m_note = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          n_vec = 0;
  int          n_fail = 0;
  int          wr_cycle = -1;
  int          wr_idx = 0;
  ent_t        wr_ent;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic logic [ENTRY_W-1:0] pack(input ent_t e);
    logic [31:0] d;
    logic [31:0] p;
    d = e.dur;
    p = e.per;
`ifdef KS_SEQ_DRUM_EN
    return {e.drum, d[DUR_WIDTH-1:0], p[DATA_WIDTH-1:0]};
`else
    return {d[DUR_WIDTH-1:0], p[DATA_WIDTH-1:0]};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_outs(input exp_t e);
    chk("pluck_o", 32'(pluck_o), 32'(e.pluck));
    chk("period_o", 32'(period_o), e.period);
    chk("drum_o", 32'(drum_o), 32'(e.drum));
    chk("note_idx_o", 32'(note_idx_o), e.note);
    chk("busy_o", 32'(busy_o), 32'(e.busy));
    chk("done_o", 32'(done_o), 32'(e.done));
  endtask

  // One clock; the LFSR model follows the reset value seen at that edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rst) m_lfsr = 16'hACE1;
    else     m_lfsr = lfsr_next(m_lfsr);
    chk("prbs_o", 32'(prbs_o), 32'(m_lfsr[PRBS_WIDTH-1:0]));
  endtask

  task automatic wr(input int idx, input int dur, input int per, input bit drum);
    tbl[idx] = '{dur, per, drum};
    wr_en_i = 1'b1;
    wr_addr_i = AW'(idx);
    wr_data_i = pack(tbl[idx]);
    tick();
    wr_en_i = 1'b0;
  endtask

  // Expected per-cycle outputs from the start edge onward; one fetch cycle per table read.
  function automatic void gen(input bit loop_en, input int limit, input int wr_fetch);
    int   idx = 0;
    int   nfetch = 0;
    ent_t e;
    q.delete();
    wr_cycle = -1;
    while (q.size() < limit) begin
      q.push_back('{1'b0, m_period, m_drum, m_note, 1'b1, 1'b0});
      if (idx < DEPTH) e = tbl[idx];
      else             e = '{0, 0, 1'b0};
      if (nfetch == wr_fetch) begin
        wr_cycle = q.size() - 1;
        tbl[wr_idx] = wr_ent;
      end
      nfetch++;
      if (idx >= DEPTH || e.dur == 0) begin
        if (loop_en && idx != 0) begin
          idx = 0;
          continue;
        end
        q.push_back('{1'b0, m_period, m_drum, m_note, 1'b0, 1'b1});
        break;
      end
      if (e.per != 0) m_period = (e.per > MAX_LENGTH) ? MAX_LENGTH : e.per;
      m_drum = DrumEn && e.drum;
      m_note = idx;
      for (int c = 0; c < e.dur * TICK_DIV; c++) begin
        q.push_back('{(c < PLUCK_CYCLES) && (e.per != 0), m_period, m_drum, m_note, 1'b1, 1'b0});
      end
      idx++;
    end
  endfunction

  // mode 0: run to completion then check idle; 1: stop_i after ncyc; 2: leave running.
  task automatic run(input bit loop_en, input int ncyc, input int mode, input int wr_fetch);
    int n;
    exp_t last;
    gen(loop_en, ncyc, wr_fetch);
    n = (ncyc < q.size()) ? ncyc : q.size();
    loop_en_i = loop_en;
    start_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      start_i = 1'b0;
      wr_en_i = 1'b0;
      check_outs(q[k]);
      if (k == wr_cycle) begin
        wr_en_i = 1'b1;
        wr_addr_i = AW'(wr_idx);
        wr_data_i = pack(wr_ent);
      end
    end
    last = q[n-1];
    m_period = last.period;
    m_drum = last.drum;
    m_note = last.note;
    if (mode == 1) begin
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wr_en_i = 1'b0;
      check_outs('{1'b0, m_period, m_drum, m_note, 1'b0, 1'b0});
    end
    if (mode != 2) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        wr_en_i = 1'b0;
        check_outs('{1'b0, m_period, m_drum, m_note, 1'b0, 1'b0});
      end
    end
    loop_en_i = 1'b0;
  endtask

  initial begin
    wr_ent = '{0, 0, 1'b0};
    for (int i = 0; i < DEPTH; i++) tbl[i] = '{0, 0, 1'b0};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_outs('{1'b0, 1, 1'b0, 0, 1'b0, 1'b0});
    tick();
    check_outs('{1'b0, 1, 1'b0, 0, 1'b0, 1'b0});

    // Single note then end of table
    wr(0, 2, 5, 1'b0);
    wr(1, 0, 0, 1'b0);
    run(1'b0, 1000, 0, -1);

    // Clamp, then a rest holds the period
    wr(0, 1, 200, 1'b1);
    wr(1, 1, 0, 1'b0);
    wr(2, 0, 0, 1'b0);
    run(1'b0, 1000, 0, -1);

    // Looping pair, aborted by stop_i
    wr(0, 1, 3, 1'b0);
    wr(1, 1, 7, 1'b1);
    wr(2, 0, 0, 1'b0);
    run(1'b1, 60, 1, -1);

    // Empty table with looping still ends
    wr(0, 0, 9, 1'b0);
    run(1'b1, 1000, 0, -1);

    // stop_i beats start_i in IDLE
    start_i = 1'b1;
    stop_i = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_outs('{1'b0, m_period, m_drum, m_note, 1'b0, 1'b0});
      tick();
    end

    // stop_i mid-pluck
    wr(0, 3, 6, 1'b0);
    wr(1, 0, 0, 1'b0);
    run(1'b0, 3, 1, -1);

    // Write entry 1 during its fetch: old data now, new data next pass
    wr(0, 1, 4, 1'b0);
    wr(1, 1, 8, 1'b0);
    wr(2, 0, 0, 1'b0);
    wr_idx = 1;
    wr_ent = '{2, 9, 1'b1};
    run(1'b1, 70, 1, 1);

    // Full table runs past the last entry, then wraps when looping
    for (int i = 0; i < DEPTH; i++) wr(i, 1, int'($urandom_range(1, 255)), 1'(($urandom) & 1));
    run(1'b0, 1000, 0, -1);
    run(1'b1, 170, 1, -1);

    // Randomized short sequences
    for (int r = 0; r < 6; r++) begin
      int len;
      bit lp;
      len = int'($urandom_range(1, 5));
      lp = 1'(($urandom) & 1);
      for (int i = 0; i < len; i++) begin
        int per;
        per = (($urandom & 3) == 0) ? 0 : int'($urandom_range(1, 255));
        wr(i, int'($urandom_range(1, 3)), per, 1'(($urandom) & 1));
      end
      wr(len, 0, 0, 1'b0);
      if (lp) run(1'b1, 150, 1, -1);
      else    run(1'b0, 1000, 0, -1);
    end

    // rst mid-note
    wr(0, 2, 6, 1'b1);
    wr(1, 0, 0, 1'b0);
    run(1'b0, 3, 2, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_period = 1;
    m_drum = 1'b0;
    m_note = 0;
    check_outs('{1'b0, 1, 1'b0, 0, 1'b0, 1'b0});
    for (int k = 0; k < 20; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
